// File: rtl/sum_uart_tx.sv
// Buffers 4-bit adder sums in a small FIFO and serialises each word as
// start / data LSB-first / optional even parity / stop on a single pin.
module sum_uart_tx #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                clr_ovf,
  output logic                                tx,
  output logic                                tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                push, drop, pop;
  logic [DATA_W-1:0]   shreg, shreg_next;
  logic                par, par_next;
  logic [BW-1:0]       bit_cnt, bit_cnt_next;
  logic [IW-1:0]       idx, idx_next;
  logic                tx_next;
  logic                bit_last;

  assign in_ready = (fifo_count != FULL);
  assign push     = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign bit_last = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      shreg   <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
      idx     <= '0;
    end else begin
      state   <= state_next;
      tx      <= tx_next;
      tx_busy <= (state_next != IDLE);
      shreg   <= shreg_next;
      par     <= par_next;
      bit_cnt <= bit_cnt_next;
      idx     <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    shreg_next = shreg;
    par_next   = par;
    idx_next   = idx;

    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_last) state_next = DATA;
      end
      DATA: begin
        if (bit_last) begin
          shreg_next = shreg >> 1;
          idx_next   = idx + 1'b1;
          if (idx == IDX_LAST) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_last) state_next = STOP;
      end
      STOP: begin
        if (bit_last) begin
          if (fifo_count != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (pop) begin
      shreg_next = mem[rd_ptr];
      par_next   = ^mem[rd_ptr];
    end
    if (state != DATA) idx_next = '0;

    // bit_cnt restarts on every bit boundary, including STOP->START re-entry
    if (state == IDLE || bit_last || state_next != state) bit_cnt_next = '0;
    else                                                   bit_cnt_next = bit_cnt + 1'b1;

    // tx is the registered image of the state being entered on this edge
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed self-checking bench for sum_uart_tx: default instance plus a
// no-parity, one-clock-per-bit instance.
module tb_sum_uart_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] in_data;
  logic       in_valid, in_ready, clr_ovf, tx, tx_busy, overflow;
  logic [2:0] fifo_count;

  logic [3:0] b_data;
  logic       b_valid, b_ready, b_clr, b_tx, b_busy, b_ovf;
  logic [2:0] b_count;

  sum_uart_tx dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clr_ovf(clr_ovf), .tx(tx), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  sum_uart_tx #(.DATA_W(4), .FIFO_DEPTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .clr_ovf(b_clr), .tx(b_tx), .tx_busy(b_busy),
    .fifo_count(b_count), .overflow(b_ovf)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] rx_q[$];
  logic       rst_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w);
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] q_pop();
    if (rx_q.size() == 0) return 'x;
    return {28'd0, rx_q.pop_front()};
  endfunction

  // Checks every cycle of one 28-cycle frame starting at the current cycle.
  task automatic expect_frame(input string tag, input logic [3:0] w);
    logic [6:0] bits;
    bits = {1'b1, ^w, w, 1'b0};
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < 4; c++) begin
        check({tag, "_tx"}, {31'd0, tx}, {31'd0, bits[b]});
        check({tag, "_busy"}, {31'd0, tx_busy}, 32'd1);
        step();
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((tx_busy || fifo_count != 3'd0) && n < 1000) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, (n >= 1000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  always @(posedge clk) if (rst) rst_seen = 1'b1;

  // Frame decoder on the default instance: samples mid-bit, queues words.
  initial begin : monitor
    logic [3:0] w;
    logic       p, s;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          repeat (4) @(negedge clk);
          w[i] = tx;
        end
        repeat (4) @(negedge clk);
        p = tx;
        repeat (4) @(negedge clk);
        s = tx;
        @(negedge clk);
        if (!rst_seen) begin
          check("mon_parity", {31'd0, p}, {31'd0, ^w});
          check("mon_stop", {31'd0, s}, 32'd1);
          rx_q.push_back(w);
        end
      end
    end
  end

  initial begin
    logic [3:0] w5 [12];
    logic [3:0] exp_b [6];
    w5    = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    exp_b = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_ovf = 1'b0;
    b_valid = 1'b0; b_data = '0; b_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_b_tx", {31'd0, b_tx}, 32'd1);
    step();

    // single word 0xB
    rx_q.delete();
    push(4'hB);
    check("single_tx_idle", {31'd0, tx}, 32'd1);
    check("single_count1", {29'd0, fifo_count}, 32'd1);
    check("single_busy0", {31'd0, tx_busy}, 32'd0);
    step();
    check("single_count0", {29'd0, fifo_count}, 32'd0);
    expect_frame("single", 4'hB);
    check("single_end_busy", {31'd0, tx_busy}, 32'd0);
    check("single_end_tx", {31'd0, tx}, 32'd1);
    check("single_rx", q_pop(), 32'hB);

    // back-to-back 0x3 then 0x0
    rx_q.delete();
    push(4'h3);
    push(4'h0);
    check("btb_count", {29'd0, fifo_count}, 32'd1);
    expect_frame("btb0", 4'h3);
    expect_frame("btb1", 4'h0);
    check("btb_end_busy", {31'd0, tx_busy}, 32'd0);
    check("btb_rx0", q_pop(), 32'h3);
    check("btb_rx1", q_pop(), 32'h0);

    // fill and overflow while frame 0xF is in flight
    rx_q.delete();
    push(4'hF);
    push(4'h1);
    push(4'h2);
    push(4'h3);
    check("fill_ready3", {31'd0, in_ready}, 32'd1);
    push(4'h4);
    check("fill_count4", {29'd0, fifo_count}, 32'd4);
    check("fill_ready0", {31'd0, in_ready}, 32'd0);
    check("fill_ovf0", {31'd0, overflow}, 32'd0);
    push(4'h5);
    check("drop_ovf1", {31'd0, overflow}, 32'd1);
    check("drop_count4", {29'd0, fifo_count}, 32'd4);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf0", {31'd0, overflow}, 32'd0);
    clr_ovf = 1'b1;
    push(4'h6);
    clr_ovf = 1'b0;
    check("clr_drop_ovf1", {31'd0, overflow}, 32'd1);
    check("clr_drop_count4", {29'd0, fifo_count}, 32'd4);
    wait_drain("fill");
    check("fill_rx_n", rx_q.size(), 32'd5);
    check("fill_rx0", q_pop(), 32'hF);
    check("fill_rx1", q_pop(), 32'h1);
    check("fill_rx2", q_pop(), 32'h2);
    check("fill_rx3", q_pop(), 32'h3);
    check("fill_rx4", q_pop(), 32'h4);

    // simultaneous push/pop, then stream enough words to wrap pointers 3 times
    rx_q.delete();
    push(w5[0]);
    push(w5[1]);
    push(w5[2]);
    repeat (26) step();
    check("pp_count_before", {29'd0, fifo_count}, 32'd2);
    in_data  = w5[3];
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("pp_count_after", {29'd0, fifo_count}, 32'd2);
    check("pp_start_tx", {31'd0, tx}, 32'd0);
    check("pp_busy", {31'd0, tx_busy}, 32'd1);
    for (int i = 4; i < 12; i++) begin
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
        step();
        n++;
      end
      check("wrap_ready_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
      push(w5[i]);
    end
    wait_drain("wrap");
    check("wrap_rx_n", rx_q.size(), 32'd12);
    for (int i = 0; i < 12; i++) check("wrap_rx", q_pop(), {28'd0, w5[i]});

    // reset during DATA bit 2 of 0xA with two words queued
    rx_q.delete();
    push(4'hA);
    push(4'h1);
    push(4'h2);
    check("mid_count2", {29'd0, fifo_count}, 32'd2);
    repeat (10) step();
    check("mid_bit1", {31'd0, tx}, 32'd1);
    step();
    check("mid_bit2", {31'd0, tx}, 32'd0);
    check("mid_ovf_pre", {31'd0, overflow}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      check("post_rst_idle", {30'd0, tx_busy, tx}, 32'd1);
    end
    check("post_rst_rx_n", rx_q.size(), 32'd0);

    // no parity, one clock per bit: 0x6
    b_data  = 4'h6;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    check("b_idle_tx", {31'd0, b_tx}, 32'd1);
    check("b_count1", {29'd0, b_count}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("b_tx", {31'd0, b_tx}, {28'd0, exp_b[i]});
      check("b_busy", {31'd0, b_busy}, 32'd1);
    end
    step();
    check("b_end_tx", {31'd0, b_tx}, 32'd1);
    check("b_end_busy", {31'd0, b_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
- Downstream stage of the 4-bit operand adder. Captures each 4-bit sum word on a strobe and buffers it in a small FIFO.
- Transmits each word on a single output pin as an asynchronous serial frame: start bit, data LSB first, optional even parity, stop bit.
- Lets the adder result leave the chip over one dedicated output pin instead of a parallel bus.

Parameters:
- DATA_W, 4, width of the sum word and of the frame data field
- FIFO_DEPTH, 4, number of buffered words; power of two, at least 2
- CLKS_PER_BIT, 4, clk cycles each serial bit is held; at least 1
- PARITY_EN, 1, 1 inserts an even-parity bit after the data field, 0 omits it

Ports:
- clk  input  1  clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-high
- in_data  input  DATA_W  sum word from the adder
- in_valid  input  1  write strobe for in_data
- in_ready  output  1  FIFO can accept a word this cycle
- clr_ovf  input  1  clears the overflow flag
- tx  output  1  serial line; idles high
- tx_busy  output  1  a frame is in progress
- fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently held in the FIFO
- overflow  output  1  sticky flag: a write was dropped

Behaviour:
- Reset: the one clock and the synchronous active-high reset are fixed for this block. rst sampled high on a clk edge forces:
  - tx=1, tx_busy=0, fifo_count=0, overflow=0, in_ready=1
  - FSM to IDLE, FIFO pointers to 0
  - a frame in progress is abandoned immediately; tx returns high on the next cycle
- in_ready:
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from registered state.
  - A pop in the same cycle does not make a full FIFO ready.
- Push:
  - Occurs when in_valid && in_ready. The word is stored and fifo_count increments on that edge.
  - in_valid && !in_ready drops the word and sets overflow on that edge.
  - overflow stays set until clr_ovf or rst. If clr_ovf and a drop occur in the same cycle, set wins.
- Pop:
  - Occurs only in the FSM transitions marked "pop" below. The head word loads into the shift register.
  - Push and pop in the same cycle: fifo_count unchanged and both operations take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. The bit counter counts 0..CLKS_PER_BIT-1 and each state holds its bit for exactly CLKS_PER_BIT cycles.
  - IDLE: tx=1. If fifo_count>0: pop, compute parity = XOR of the word, go to START.
  - START: tx=0, then go to DATA with bit index 0.
  - DATA: tx = shift-register LSB. Shift right after each bit. After bit DATA_W-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = parity bit (even: total ones across data+parity is even).
  - STOP: tx=1. On its last cycle: if fifo_count>0, pop and go straight to START with no idle gap; else go to IDLE.
- tx is registered and reflects the state entered on the previous edge. The start bit appears on tx the cycle after the pop edge.
- Frame length = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles. Defaults give 28.
- Latency: a word pushed into an empty FIFO while idle is popped on the next edge; its start bit is on tx 2 cycles after the push edge.
- tx_busy = (state != IDLE), registered alongside state.
- Data and parity bits are taken from the popped copy in the shift register. Later pushes never alter a frame in flight.

Test Plan:
- Single word 0xB, defaults:
  - Push at cycle 0; tx is 1 at cycle 1.
  - tx sequence from cycle 2: 0,1,1,0,1,1(parity),1(stop), each held 4 cycles.
  - tx_busy high for cycles 2..29; fifo_count returns to 0 at cycle 2.
- Back-to-back words 0x3 then 0x0 pushed on consecutive cycles:
  - Second start bit follows the first stop bit with zero idle cycles.
  - Parity bits are 0 and 0; total 56 busy cycles.
- Fill and overflow while the line is busy:
  - Push 5 words 0x1..0x5 while frame 0xF is in flight; fifo_count reaches 4 and in_ready=0.
  - Fifth word is dropped and overflow=1.
  - Output order is 0xF,0x1,0x2,0x3,0x4.
  - clr_ovf pulse clears overflow; clr_ovf with a simultaneous drop leaves overflow=1.
- Simultaneous push and pop:
  - With fifo_count=2, push on the STOP-last-cycle pop edge; fifo_count stays 2.
  - Pointer wrap is exercised over 3 full FIFO cycles; data order is preserved.
- Reset mid-frame:
  - Assert rst during DATA bit 2 of 0xA with 2 words queued.
  - Next cycle: tx=1, tx_busy=0, fifo_count=0, overflow=0; no further frames are emitted.
- PARITY_EN=0, CLKS_PER_BIT=1:
  - Word 0x6 gives tx 0,0,1,1,0,1 in 6 consecutive cycles.
